// File: rtl/therm_phase_decoder.sv
// Two-stage decoder from a circular thermometer word (ring-oscillator taps) to a phase code.
// Define THERM_BUBBLE_FIX_EN to add 3-tap circular majority bubble correction ahead of the decoder.
module therm_phase_decoder #(
    parameter int N_TAP  = 32,
    parameter int CODE_W = $clog2(N_TAP),
    parameter int ERR_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_TAP-1:0]  in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [CODE_W-1:0] out_code,
    output logic              out_err,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic              err_clr,
    output logic [ERR_W-1:0]  err_cnt
);

    localparam logic [N_TAP-1:0]   BASE  = {{(N_TAP/2){1'b0}}, {(N_TAP/2){1'b1}}};
    localparam logic [2*N_TAP-1:0] BASE2 = {BASE, BASE};

    logic              s1_valid_q, s1_valid_d;
    logic [N_TAP-1:0]  s1_data_q, s1_data_d;
    logic              out_valid_q, out_valid_d;
    logic [CODE_W-1:0] out_code_q, out_code_d;
    logic              out_err_q, out_err_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;

    logic              s2_adv;
    logic [N_TAP-1:0]  fixed_word;
    logic [CODE_W-1:0] dec_code;
    logic              dec_err;

    assign s2_adv   = !out_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_adv;

`ifdef THERM_BUBBLE_FIX_EN
    always_comb begin
        fixed_word = '0;
        for (int i = 0; i < N_TAP; i++) begin
            fixed_word[i] = (s1_data_q[(i + N_TAP - 1) % N_TAP] & s1_data_q[i])
                          | (s1_data_q[i] & s1_data_q[(i + 1) % N_TAP])
                          | (s1_data_q[(i + N_TAP - 1) % N_TAP] & s1_data_q[(i + 1) % N_TAP]);
        end
    end
`else
    assign fixed_word = s1_data_q;
`endif

    // A slice of the doubled base pattern starting at bit k is the base rotated right by k.
    always_comb begin
        dec_code = '0;
        dec_err  = 1'b1;
        for (int k = 0; k < N_TAP; k++) begin
            if (fixed_word == BASE2[k +: N_TAP]) begin
                dec_code = CODE_W'(k);
                dec_err  = 1'b0;
            end
        end
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_data_d   = s1_data_q;
        out_valid_d = out_valid_q;
        out_code_d  = out_code_q;
        out_err_d   = out_err_q;
        err_cnt_d   = err_cnt_q;

        if (in_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_data_d = in_data;
            end
        end

        if (s2_adv) begin
            out_valid_d = s1_valid_q;
            out_code_d  = s1_valid_q ? dec_code : '0;
            out_err_d   = s1_valid_q && dec_err;
        end

        // Clear wins over a same-cycle increment.
        if (err_clr) begin
            err_cnt_d = '0;
        end else if (s2_adv && s1_valid_q && dec_err && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            out_valid_q <= 1'b0;
            out_code_q  <= '0;
            out_err_q   <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            out_valid_q <= out_valid_d;
            out_code_q  <= out_code_d;
            out_err_q   <= out_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_code  = out_code_q;
    assign out_err   = out_err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_therm_phase_decoder.sv
// Scoreboard bench for therm_phase_decoder: 32-tap instance under streaming/backpressure/reset,
// plus a small 8-tap instance for directed code checks.
module tb_therm_phase_decoder;

    typedef struct {
        logic [4:0] code;
        logic       err;
        int         t;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  out_code;
    logic        out_err;
    logic        out_valid;
    logic        out_ready;
    logic        err_clr;
    logic [7:0]  err_cnt;

    logic [7:0]  in_data8;
    logic        in_valid8;
    logic        in_ready8;
    logic [2:0]  out_code8;
    logic        out_err8;
    logic        out_valid8;
    logic [7:0]  err_cnt8;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   exp_errs = 0;
    bit   chk_lat = 1'b0;

    therm_phase_decoder #(.N_TAP(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_code(out_code), .out_err(out_err), .out_valid(out_valid), .out_ready(out_ready),
        .err_clr(err_clr), .err_cnt(err_cnt)
    );

    therm_phase_decoder #(.N_TAP(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data8), .in_valid(in_valid8), .in_ready(in_ready8),
        .out_code(out_code8), .out_err(out_err8), .out_valid(out_valid8), .out_ready(1'b1),
        .err_clr(1'b0), .err_cnt(err_cnt8)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] legal32(int k);
        logic [31:0] w;
        for (int j = 0; j < 32; j++) w[j] = (((j + k) % 32) < 16);
        return w;
    endfunction

    function automatic exp_t model(logic [31:0] raw);
        exp_t e;
        logic [31:0] w;
        w = raw;
`ifdef THERM_BUBBLE_FIX_EN
        for (int i = 0; i < 32; i++) begin
            int n;
            n = int'(raw[(i + 31) % 32]) + int'(raw[i]) + int'(raw[(i + 1) % 32]);
            w[i] = (n >= 2);
        end
`endif
        e.code = '0;
        e.err  = 1'b1;
        e.t    = 0;
        for (int k = 0; k < 32; k++) begin
            if (w == legal32(k)) begin
                e.code = 5'(k);
                e.err  = 1'b0;
            end
        end
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Push on every handshake, compare the queue head whenever the output is valid (held or moving).
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
        end else begin
            if (in_valid && in_ready) begin
                exp_t e;
                e = model(in_data);
                e.t = cyc;
                if (e.err && exp_errs < 255) exp_errs++;
                q.push_back(e);
            end
            if (out_valid) begin
                tests++;
                assert (q.size() > 0) else begin
                    fails++;
                    $error("[TB] FAIL stale_out: observed code %0d with empty scoreboard, expected no output", out_code);
                end
                if (q.size() > 0) begin
                    checkOutput("out_code", 32'(out_code), 32'(q[0].code));
                    checkOutput("out_err", 32'(out_err), 32'(q[0].err));
                    if (out_ready) begin
                        if (chk_lat) checkOutput("latency", 32'(cyc - q[0].t), 32'd2);
                        void'(q.pop_front());
                    end
                end
            end
        end
    end

    // Called at posedge+1; holds the word until the DUT takes it.
    task automatic applyStimulus(input logic [31:0] w);
        bit acc;
        in_data  = w;
        in_valid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) return;
        end
        fails++;
        tests++;
        $error("[TB] FAIL accept_timeout: observed in_ready 0 for 50 cycles expected 1");
    endtask

    task automatic idleCycles(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic waitDrain();
        in_valid = 1'b0;
        for (int n = 0; n < 100 && q.size() != 0; n++) begin
            @(posedge clk);
            #1;
        end
        idleCycles(2);
        checkOutput("drain", 32'(q.size()), 32'd0);
    endtask

    initial begin
        logic [7:0] w8 [4];
        logic [2:0] c8 [4];
        w8 = '{8'h0F, 8'h87, 8'hF0, 8'h1E};
        c8 = '{3'd0, 3'd1, 3'd4, 3'd7};

        rst_n = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b1; err_clr = 1'b0;
        in_data8 = '0; in_valid8 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_code", 32'(out_code), 32'd0);
        checkOutput("rst_out_err", 32'(out_err), 32'd0);
        checkOutput("rst_err_cnt", 32'(err_cnt), 32'd0);
        @(posedge clk);
        #1;

        chk_lat = 1'b1;
        for (int k = 0; k < 32; k++) applyStimulus(legal32(k));
        waitDrain();
        chk_lat = 1'b0;
        checkOutput("legal_err_cnt", 32'(err_cnt), 32'd0);

        applyStimulus(32'h0000FEFF);
        waitDrain();
        checkOutput("bubble_err_cnt", 32'(err_cnt), 32'(exp_errs));

        // Backpressure: two words get in, then the pipe is full until out_ready returns.
        out_ready = 1'b0;
        applyStimulus(legal32(3));
        applyStimulus(legal32(7));
        in_data  = legal32(12);
        in_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
            checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        applyStimulus(legal32(12));
        applyStimulus(32'h12345678);
        applyStimulus(legal32(20));
        waitDrain();
        checkOutput("bp_err_cnt", 32'(err_cnt), 32'(exp_errs));

        repeat (300) applyStimulus(32'hFFFFFFFF);
        waitDrain();
        checkOutput("sat_err_cnt", 32'(err_cnt), 32'd255);

        applyStimulus(32'hFFFFFFFF);
        in_valid = 1'b0;
        err_clr  = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        exp_errs = 0;
        @(negedge clk);
        checkOutput("clr_err_cnt", 32'(err_cnt), 32'd0);
        waitDrain();

        // Reset with two illegal words in flight.
        applyStimulus(32'hFFFFFFFF);
        applyStimulus(32'h00000000);
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_errs = 0;
        repeat (3) begin
            @(negedge clk);
            checkOutput("mid_rst_out_valid", 32'(out_valid), 32'd0);
            checkOutput("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
            @(posedge clk);
            #1;
        end

        for (int i = 0; i < 4; i++) begin
            in_data8  = w8[i];
            in_valid8 = 1'b1;
            @(posedge clk);
            #1;
            in_valid8 = 1'b0;
            @(posedge clk);
            @(negedge clk);
            checkOutput("n8_valid", 32'(out_valid8), 32'd1);
            checkOutput("n8_code", 32'(out_code8), 32'(c8[i]));
            checkOutput("n8_err", 32'(out_err8), 32'd0);
            @(posedge clk);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
